morse_key_sequencer: RTL and testbench
======================================

Name: morse_key_sequencer

Overview:
- Sits between ps2_controller and morse_code_encoder in tt_um_ps2_morse_encoder_top.
- Filters the PS/2 scan-code stream: drops break sequences and prefixes, and decodes the control keys (Enter, Backspace, F1–F4).
- Buffers typed make codes in a FIFO.
- On Enter, feeds the buffered codes one at a time to the encoder over a start/busy handshake, and drives the encoder speed select.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- AW, 4, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous reset, active-low.
- scan_code  input  8  byte from ps2_controller.
- scan_valid  input  1  one-cycle strobe; scan_code is valid in that cycle.
- enc_busy  input  1  encoder is emitting a character, tone or gap.
- enc_start  output  1  one-cycle request to the encoder.
- enc_code  output  8  scan code for the encoder; held stable from enc_start until enc_busy falls.
- speed_sel  output  2  encoder speed index (F1=0, F2=1, F3=2, F4=3).
- buf_count  output  AW+1  number of FIFO entries, 0..DEPTH.
- buf_full  output  1  buf_count == DEPTH.
- playing  output  1  playback in progress.
- overflow  output  1  sticky flag; set when a code is dropped because the FIFO is full.

Behaviour:
- Reset: rst_n low asynchronously clears all state. enc_start=0, enc_code=0x00, speed_sel=0, buf_count=0, buf_full=0, playing=0, overflow=0, break_pending=0, FSM in COLLECT.
- Reset mid-playback abandons the character and the FIFO contents.
- Input filter, evaluated only on cycles with scan_valid=1, in this priority order:
  - 0xF0: set break_pending; store nothing.
  - Any byte while break_pending=1: discard it and clear break_pending (this covers released Enter, F-keys, etc.).
  - 0xE0: ignore the byte; break_pending is unchanged.
  - 0x05/0x06/0x04/0x0C (F1/F2/F3/F4): speed_sel becomes 0/1/2/3 on the next cycle. Accepted in any state.
  - 0x5A (Enter): in COLLECT with buf_count>0, go to ISSUE. Otherwise ignore.
  - 0x66 (Backspace): in COLLECT with buf_count>0, remove the newest entry (decrement the write pointer). Otherwise ignore.
  - Any other byte: push it to the FIFO, in any state. If the FIFO is full, drop it and set overflow.
- FIFO:
  - Circular, wrap-around modulo DEPTH.
  - buf_count updates one cycle after the accepting scan_valid.
  - Push and pop in the same cycle: buf_count is unchanged, and this is legal even when full.
  - Backspace and pop never coincide, because Backspace is only honoured in COLLECT.
- FSM:
  - COLLECT: playing=0. Enter with buf_count>0 moves to ISSUE.
  - ISSUE: playing=1. Wait for enc_busy=0. Then, in one cycle: pop the head into enc_code, pulse enc_start for exactly 1 cycle, and go to WAIT_ACK.
  - WAIT_ACK: wait for enc_busy=1 (the encoder guarantees this within 1 cycle), then go to WAIT_DONE.
  - WAIT_DONE: on enc_busy falling to 0, go to ISSUE if buf_count>0, else to COLLECT.
- Codes pushed during playback are played in the same run.
- Latency from Enter to enc_start: 2 cycles after the Enter scan_valid if the encoder is idle.
- overflow is cleared only by reset.
- enc_code keeps the last issued value while in COLLECT.
- Space (0x29) is an ordinary stored code; the encoder turns it into a word gap.

Test Plan:
- Make/break filtering: send 1C, F0, 1C, 32, 5A with an encoder model whose busy lasts 100 cycles.
  - Expected: buf_count reaches 2 before Enter.
  - Expected: exactly two enc_start pulses, with enc_code 0x1C then 0x32.
  - Expected: playing falls after the second busy ends, and buf_count=0.
- Backspace: send 1C, 29, 32, 66, 5A.
  - Expected: enc_code sequence 0x1C, 0x29.
  - Expected: Backspace on an empty buffer leaves buf_count=0.
- Speed select: send 0C, then F0, 0C.
  - Expected: speed_sel=3 one cycle after the first strobe.
  - Expected: the break sequence leaves speed_sel unchanged and nothing is stored.
- Overflow and wrap: push DEPTH+1 codes 0x10..0x20.
  - Expected: buf_full=1, buf_count=16, overflow=1.
  - Expected: Enter plays 0x10..0x1F in order.
  - Then push 3 more codes and press Enter: FIFO order is preserved across the pointer wrap.
- Append during playback and guarded Enter: during playback of A, B, push 21 and send 5A.
  - Expected: played sequence is 1C, 32, 21.
  - Expected: the extra Enter causes no additional run.
  - Expected: enc_start is never asserted while enc_busy=1.
- Asynchronous reset: drop rst_n in WAIT_DONE.
  - Expected: all outputs reach their reset values immediately, with no clock edge needed.
  - Expected: after release, Enter with an empty buffer causes no enc_start.

Source files
------------

// File: rtl/morse_key_sequencer.sv
// Scan-code filter, typed-character FIFO and playback sequencer between the
// PS/2 receiver and the Morse encoder.
module morse_key_sequencer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    scan_code,
   input  logic          scan_valid,
   input  logic          enc_busy,
   output logic          enc_start,
   output logic [7:0]    enc_code,
   output logic [1:0]    speed_sel,
   output logic [AW:0]   buf_count,
   output logic          buf_full,
   output logic          playing,
   output logic          overflow
);

   localparam logic [1:0] COLLECT   = 2'd0;
   localparam logic [1:0] ISSUE     = 2'd1;
   localparam logic [1:0] WAIT_ACK  = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   localparam logic [7:0] KEY_BREAK  = 8'hF0;
   localparam logic [7:0] KEY_EXT    = 8'hE0;
   localparam logic [7:0] KEY_F1     = 8'h05;
   localparam logic [7:0] KEY_F2     = 8'h06;
   localparam logic [7:0] KEY_F3     = 8'h04;
   localparam logic [7:0] KEY_F4     = 8'h0C;
   localparam logic [7:0] KEY_ENTER  = 8'h5A;
   localparam logic [7:0] KEY_BKSP   = 8'h66;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          break_q, break_d;
   logic [1:0]    speed_q, speed_d;
   logic          overflow_q, overflow_d;
   logic          start_q, start_d;
   logic [7:0]    code_q, code_d;

   logic [7:0]    mem [DEPTH];

   logic          push_req, push_ok, pop, bksp, enter, full, nonempty;

   assign full     = (count_q == FULL_CNT);
   assign nonempty = (count_q != '0);
   assign pop      = (state_q == ISSUE) && !enc_busy;
   assign push_ok  = push_req && (!full || pop);

   // Input filter: break prefix swallows the following byte; control keys
   // are decoded; everything else is a character to store.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      break_d  = break_q;
      speed_d  = speed_q;
      push_req = 1'b0;
      bksp     = 1'b0;
      enter    = 1'b0;
      if (scan_valid) begin
         if (scan_code == KEY_BREAK) begin
            break_d = 1'b1;
         end else if (break_q) begin
            break_d = 1'b0;
         end else if (scan_code == KEY_EXT) begin
            break_d = break_q;
         end else if (scan_code == KEY_F1) begin
            speed_d = 2'd0;
         end else if (scan_code == KEY_F2) begin
            speed_d = 2'd1;
         end else if (scan_code == KEY_F3) begin
            speed_d = 2'd2;
         end else if (scan_code == KEY_F4) begin
            speed_d = 2'd3;
         end else if (scan_code == KEY_ENTER) begin
            enter = (state_q == COLLECT) && nonempty;
         end else if (scan_code == KEY_BKSP) begin
            bksp = (state_q == COLLECT) && nonempty;
         end else begin
            push_req = 1'b1;
         end
      end
   end

   // FIFO bookkeeping; backspace only happens in COLLECT so it never meets a pop.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (push_req && !push_ok);
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (bksp)    wr_ptr_d = wr_ptr_q - AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop)       count_d = count_q + 1'b1;
      else if (pop && !push_ok)  count_d = count_q - 1'b1;
      else if (bksp)             count_d = count_q - 1'b1;
   end

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      code_d  = code_q;
      case (state_q)
         COLLECT:   if (enter) state_d = ISSUE;
         ISSUE: begin
            if (pop) begin
               start_d = 1'b1;
               code_d  = mem[rd_ptr_q];
               state_d = WAIT_ACK;
            end
         end
         WAIT_ACK:  if (enc_busy) state_d = WAIT_DONE;
         WAIT_DONE: if (!enc_busy) state_d = nonempty ? ISSUE : COLLECT;
         default:   state_d = COLLECT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= COLLECT;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         break_q    <= 1'b0;
         speed_q    <= 2'd0;
         overflow_q <= 1'b0;
         start_q    <= 1'b0;
         code_q     <= 8'h00;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         break_q    <= break_d;
         speed_q    <= speed_d;
         overflow_q <= overflow_d;
         start_q    <= start_d;
         code_q     <= code_d;
      end
   end

   // NOTE: storage is not reset; the pointers and count define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= scan_code;
   end

   assign enc_start = start_q;
   assign enc_code  = code_q;
   assign speed_sel = speed_q;
   assign buf_count = count_q;
   assign buf_full  = full;
   assign playing   = (state_q != COLLECT);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with a fixed-length encoder busy model.
module tb_morse_key_sequencer;

   localparam int DEPTH    = 16;
   localparam int AW       = 4;
   localparam int BUSY_LEN = 100;
   localparam int IDLE_MAX = 20000;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    scan_code = 8'h00;
   logic          scan_valid = 1'b0;
   logic          enc_busy;
   logic          enc_start;
   logic [7:0]    enc_code;
   logic [1:0]    speed_sel;
   logic [AW:0]   buf_count;
   logic          buf_full;
   logic          playing;
   logic          overflow;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] log_q [64];
   int         n_log = 0;
   int         start_while_busy = 0;
   int         hold_err = 0;
   logic [7:0] held_code = 8'h00;
   int         busy_cnt;

   morse_key_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .enc_busy   (enc_busy),
      .enc_start  (enc_start),
      .enc_code   (enc_code),
      .speed_sel  (speed_sel),
      .buf_count  (buf_count),
      .buf_full   (buf_full),
      .playing    (playing),
      .overflow   (overflow)
   );

   always #10 clk = ~clk;

   // Encoder model: busy for BUSY_LEN cycles after each start.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_busy <= 1'b0;
         busy_cnt <= 0;
      end else if (enc_start) begin
         enc_busy <= 1'b1;
         busy_cnt <= BUSY_LEN;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end else begin
         busy_cnt <= 0;
         enc_busy <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (enc_start) begin
            if (n_log < 64) log_q[n_log] = enc_code;
            n_log = n_log + 1;
            held_code = enc_code;
            if (enc_busy) start_while_busy = start_while_busy + 1;
         end else if (enc_busy && enc_code !== held_code) begin
            hold_err = hold_err + 1;
         end
      end
   end

   task automatic send(input logic [7:0] code);
      @(negedge clk);
      scan_code  = code;
      scan_valid = 1'b1;
      @(negedge clk);
      scan_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < IDLE_MAX && playing; i++) @(negedge clk);
      vectors++;
      if (playing !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_idle_timeout: playing=%b required 0", name, playing);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      vectors++;
      if ({enc_start, enc_code, speed_sel, buf_count, buf_full, playing, overflow} !== 17'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: start=%b code=%h speed=%0d count=%0d full=%b play=%b ovf=%b required all 0",
                  enc_start, enc_code, speed_sel, buf_count, buf_full, playing, overflow);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (buf_count !== 0 || playing !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release: count=%0d play=%b required 0/0", buf_count, playing);
      end
   endtask

   task automatic test_filter;
      n_log = 0;
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'h32);
      vectors++;
      if (buf_count !== 5'd2) begin
         miscompares++;
         $display("FAIL filter_count: got %0d required 2", buf_count);
      end
      send(8'h5A);
      vectors++;
      if (playing !== 1'b1 || enc_start !== 1'b0) begin
         miscompares++;
         $display("FAIL filter_enter_cycle1: play=%b start=%b required 1/0", playing, enc_start);
      end
      @(negedge clk);
      vectors++;
      if (enc_start !== 1'b1 || enc_code !== 8'h1C) begin
         miscompares++;
         $display("FAIL filter_latency: start=%b code=%h required 1/1c", enc_start, enc_code);
      end
      wait_idle("filter");
      vectors++;
      if (n_log !== 2 || log_q[0] !== 8'h1C || log_q[1] !== 8'h32) begin
         miscompares++;
         $display("FAIL filter_sequence: n=%0d codes=%h %h required 2 1c 32", n_log, log_q[0], log_q[1]);
      end
      vectors++;
      if (buf_count !== 0 || enc_busy !== 1'b0) begin
         miscompares++;
         $display("FAIL filter_end: count=%0d busy=%b required 0/0", buf_count, enc_busy);
      end
      vectors++;
      if (enc_code !== 8'h32) begin
         miscompares++;
         $display("FAIL filter_code_kept: got %h required 32", enc_code);
      end
   endtask

   task automatic test_backspace;
      n_log = 0;
      send(8'h66);
      vectors++;
      if (buf_count !== 0) begin
         miscompares++;
         $display("FAIL bksp_empty: count=%0d required 0", buf_count);
      end
      send(8'h1C); send(8'h29); send(8'h32); send(8'h66);
      vectors++;
      if (buf_count !== 5'd2) begin
         miscompares++;
         $display("FAIL bksp_count: got %0d required 2", buf_count);
      end
      send(8'h5A);
      wait_idle("bksp");
      vectors++;
      if (n_log !== 2 || log_q[0] !== 8'h1C || log_q[1] !== 8'h29) begin
         miscompares++;
         $display("FAIL bksp_sequence: n=%0d codes=%h %h required 2 1c 29", n_log, log_q[0], log_q[1]);
      end
   endtask

   task automatic test_speed;
      logic [7:0] keys [4];
      logic [1:0] exp  [4];
      keys = '{8'h0C, 8'h05, 8'h06, 8'h04};
      exp  = '{2'd3, 2'd0, 2'd1, 2'd2};
      send(keys[0]);
      vectors++;
      if (speed_sel !== 2'd3) begin
         miscompares++;
         $display("FAIL speed_f4: got %0d required 3", speed_sel);
      end
      send(8'hF0); send(8'h0C);
      vectors++;
      if (speed_sel !== 2'd3 || buf_count !== 0) begin
         miscompares++;
         $display("FAIL speed_break: speed=%0d count=%0d required 3/0", speed_sel, buf_count);
      end
      send(8'hF0); send(8'h05);
      vectors++;
      if (speed_sel !== 2'd3) begin
         miscompares++;
         $display("FAIL speed_break_f1: got %0d required 3", speed_sel);
      end
      for (int i = 1; i < 4; i++) begin
         send(keys[i]);
         vectors++;
         if (speed_sel !== exp[i]) begin
            miscompares++;
            $display("FAIL speed_key_%h: got %0d required %0d", keys[i], speed_sel, exp[i]);
         end
      end
      send(8'hE0);
      vectors++;
      if (speed_sel !== 2'd2 || buf_count !== 0) begin
         miscompares++;
         $display("FAIL speed_e0: speed=%0d count=%0d required 2/0", speed_sel, buf_count);
      end
   endtask

   task automatic test_overflow;
      logic [7:0] tail [3];
      tail = '{8'h1B, 8'h23, 8'h2B};
      n_log = 0;
      for (int i = 0; i <= DEPTH; i++) send(8'(8'h10 + i));
      vectors++;
      if (buf_full !== 1'b1 || buf_count !== 5'd16 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_flags: full=%b count=%0d ovf=%b required 1/16/1", buf_full, buf_count, overflow);
      end
      send(8'h5A);
      wait_idle("ovf");
      vectors++;
      if (n_log !== DEPTH) begin
         miscompares++;
         $display("FAIL ovf_play_count: got %0d required %0d", n_log, DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         vectors++;
         if (log_q[i] !== 8'(8'h10 + i)) begin
            miscompares++;
            $display("FAIL ovf_play_%0d: got %h required %h", i, log_q[i], 8'(8'h10 + i));
         end
      end
      n_log = 0;
      for (int i = 0; i < 3; i++) send(tail[i]);
      send(8'h5A);
      wait_idle("wrap");
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (log_q[i] !== tail[i]) begin
            miscompares++;
            $display("FAIL wrap_play_%0d: got %h required %h", i, log_q[i], tail[i]);
         end
      end
      vectors++;
      if (n_log !== 3 || overflow !== 1'b1 || buf_full !== 1'b0) begin
         miscompares++;
         $display("FAIL wrap_end: n=%0d ovf=%b full=%b required 3/1/0", n_log, overflow, buf_full);
      end
   endtask

   task automatic test_append;
      n_log = 0;
      send(8'h1C); send(8'h32); send(8'h5A);
      for (int i = 0; i < 10 && n_log == 0; i++) @(negedge clk);
      vectors++;
      if (n_log !== 1) begin
         miscompares++;
         $display("FAIL append_first_start: n=%0d required 1", n_log);
      end
      send(8'h21); send(8'h5A);
      wait_idle("append");
      repeat (10) @(negedge clk);
      vectors++;
      if (n_log !== 3 || log_q[0] !== 8'h1C || log_q[1] !== 8'h32 || log_q[2] !== 8'h21) begin
         miscompares++;
         $display("FAIL append_sequence: n=%0d codes=%h %h %h required 3 1c 32 21",
                  n_log, log_q[0], log_q[1], log_q[2]);
      end
      vectors++;
      if (playing !== 1'b0 || buf_count !== 0) begin
         miscompares++;
         $display("FAIL append_no_rerun: play=%b count=%0d required 0/0", playing, buf_count);
      end
      vectors++;
      if (start_while_busy !== 0) begin
         miscompares++;
         $display("FAIL start_while_busy: got %0d required 0", start_while_busy);
      end
      vectors++;
      if (hold_err !== 0) begin
         miscompares++;
         $display("FAIL code_hold: got %0d changes required 0", hold_err);
      end
   endtask

   task automatic test_async_reset;
      n_log = 0;
      send(8'h1C); send(8'h32); send(8'h5A);
      for (int i = 0; i < 20 && !enc_busy; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      vectors++;
      if (enc_busy !== 1'b1 || playing !== 1'b1) begin
         miscompares++;
         $display("FAIL areset_setup: busy=%b play=%b required 1/1", enc_busy, playing);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({enc_start, enc_code, speed_sel, buf_count, buf_full, playing, overflow} !== 17'h0) begin
         miscompares++;
         $display("FAIL areset_outputs: start=%b code=%h speed=%0d count=%0d full=%b play=%b ovf=%b required all 0",
                  enc_start, enc_code, speed_sel, buf_count, buf_full, playing, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      n_log = 0;
      send(8'h5A);
      repeat (10) @(negedge clk);
      vectors++;
      if (n_log !== 0 || playing !== 1'b0) begin
         miscompares++;
         $display("FAIL areset_empty_enter: starts=%0d play=%b required 0/0", n_log, playing);
      end
      send(8'hF0); send(8'h55); send(8'h55);
      vectors++;
      if (buf_count !== 5'd1) begin
         miscompares++;
         $display("FAIL areset_break_cleared: count=%0d required 1", buf_count);
      end
   endtask

   initial begin
      test_reset();
      test_filter();
      test_backspace();
      test_speed();
      test_overflow();
      test_append();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
